// File: rtl/inst_wait_stage.sv
// Instruction wait stage: holds fetched PCs in order until their bus data arrives, then hands them to decode.
// Optional macro IW_DEPTH2_EN selects a two-entry queue (two outstanding fetches); the default is one entry.
module inst_wait_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        cancelled_i,
    input  logic        exc_i,
    input  logic        exc_miss_i,
    input  logic [4:0]  exccode_i,
    output logic        ready_o,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    input  logic        ready_i,
    input  logic        cancel_i
);
`ifdef IW_DEPTH2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int PW = 1;
    localparam logic [1:0] DEPTH = 2'(D);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic        exc_miss;
        logic [4:0]  exccode;
        logic        filled;
        logic        drop;
    } entry_t;

    entry_t          ent_q [D];
    entry_t          ent_d [D];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    entry_t          head;
    logic            pop, push, found;
    logic [PW-1:0]   idx_v, fill_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == D - 1) ? '0 : p + 1'b1;
    endfunction

    // Filled implies resident: the filled bit is cleared whenever a slot pops.
    assign head    = ent_q[rd_ptr_q];
    assign pop     = head.filled && (head.drop || ready_i);
    assign ready_o = (cnt_q < DEPTH) || pop;
    assign push    = valid_i && ready_o;

    assign valid_o    = head.filled && !head.drop;
    assign pc_o       = head.pc;
    assign inst_o     = head.inst;
    assign exc_o      = head.exc;
    assign exc_miss_o = head.exc_miss;
    assign exccode_o  = head.exccode;

    always_comb begin
        found    = 1'b0;
        fill_idx = '0;
        idx_v    = '0;
        for (int k = 0; k < D; k++) begin
            idx_v = PW'((int'(rd_ptr_q) + k) % D);
            if (!found && (k < int'(cnt_q)) && !ent_q[idx_v].filled) begin
                found    = 1'b1;
                fill_idx = idx_v;
            end
        end
    end

    // Update order: fill, cancel, pop, push. Fill and pop never hit the same slot
    // (one needs unfilled, the other filled); push may reuse the slot just popped.
    always_comb begin
        for (int i = 0; i < D; i++) ent_d[i] = ent_q[i];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (inst_data_ok && found) begin
            ent_d[fill_idx].inst   = inst_rdata;
            ent_d[fill_idx].filled = 1'b1;
        end
        if (cancel_i) begin
            for (int i = 0; i < D; i++) ent_d[i].drop = 1'b1;
        end
        if (pop) begin
            ent_d[rd_ptr_q].filled = 1'b0;
            ent_d[rd_ptr_q].drop   = 1'b0;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            ent_d[wr_ptr_q].pc       = pc_i;
            ent_d[wr_ptr_q].inst     = '0;
            ent_d[wr_ptr_q].exc      = exc_i;
            ent_d[wr_ptr_q].exc_miss = exc_miss_i;
            ent_d[wr_ptr_q].exccode  = exccode_i;
            ent_d[wr_ptr_q].filled   = exc_i;
            ent_d[wr_ptr_q].drop     = cancelled_i || cancel_i;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) ent_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < D; i++) ent_q[i] <= ent_d[i];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_inst_wait_stage.sv
// Randomized bench for inst_wait_stage with an in-bench queue model plus directed literal checks.
module tb_inst_wait_stage;
`ifdef IW_DEPTH2_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic        valid_i = 0, cancelled_i = 0, exc_i = 0, exc_miss_i = 0;
    logic [31:0] pc_i = 0, inst_rdata = 0, pc_o, inst_o;
    logic [4:0]  exccode_i = 0, exccode_o;
    logic        inst_data_ok = 0, ready_i = 0, cancel_i = 0;
    logic        ready_o, valid_o, exc_o, exc_miss_o;

    inst_wait_stage dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .cancelled_i(cancelled_i),
        .exc_i(exc_i), .exc_miss_i(exc_miss_i), .exccode_i(exccode_i), .ready_o(ready_o),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .valid_o(valid_o), .pc_o(pc_o),
        .inst_o(inst_o), .exc_o(exc_o), .exc_miss_o(exc_miss_o), .exccode_o(exccode_o),
        .ready_i(ready_i), .cancel_i(cancel_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, inst;
        bit          exc, miss;
        logic [4:0]  code;
        bit          filled, drop;
    } me_t;
    me_t q[$];
    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return q.size() > 0 && q[0].filled && !q[0].drop;
    endfunction

    // Called at a falling edge; returns at the next falling edge after one rising edge.
    task automatic cyc(input bit v, input logic [31:0] pc, input bit cin, input bit ex,
                       input bit miss, input logic [4:0] code, input bit dok,
                       input logic [31:0] rd, input bit rdy, input bit canc);
        bit pop, mrdy, push, done;
        chk("valid_o", {31'b0, valid_o}, {31'b0, m_valid()});
        if (m_valid()) begin
            chk("pc_o", pc_o, q[0].pc);
            if (!q[0].exc) chk("inst_o", inst_o, q[0].inst);
            chk("exc_o", {31'b0, exc_o}, {31'b0, q[0].exc});
            chk("exc_miss_o", {31'b0, exc_miss_o}, {31'b0, q[0].miss});
            chk("exccode_o", {27'b0, exccode_o}, {27'b0, q[0].code});
        end
        valid_i = v; pc_i = pc; cancelled_i = cin; exc_i = ex; exc_miss_i = miss;
        exccode_i = code; inst_data_ok = dok; inst_rdata = rd; ready_i = rdy; cancel_i = canc;
        #1;
        pop  = q.size() > 0 && q[0].filled && (q[0].drop || rdy);
        mrdy = (q.size() < D) || pop;
        chk("ready_o", {31'b0, ready_o}, {31'b0, mrdy});
        push = v && mrdy;
        if (dok) begin
            done = 0;
            foreach (q[i]) if (!done && !q[i].filled) begin
                q[i].inst = rd; q[i].filled = 1; done = 1;
            end
        end
        if (canc) foreach (q[i]) q[i].drop = 1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{pc: pc, inst: 32'h0, exc: ex, miss: miss, code: code,
                                filled: ex, drop: cin || canc});
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic do_reset();
        reset = 1; valid_i = 0; inst_data_ok = 0; cancel_i = 0; ready_i = 0;
        @(negedge clk); @(negedge clk);
        reset = 0;
        q.delete();
    endtask

    function automatic int unfilled();
        int n = 0;
        foreach (q[i]) if (!q[i].filled) n++;
        return n;
    endfunction

    initial begin
        @(negedge clk);
        do_reset();
        #1;
        chk("rst valid_o", {31'b0, valid_o}, 32'd0);
        chk("rst pc_o", pc_o, 32'd0);
        chk("rst inst_o", inst_o, 32'd0);
        chk("rst exc", {29'b0, exc_o, exc_miss_o, 1'b0}, 32'd0);
        chk("rst exccode_o", {27'b0, exccode_o}, 32'd0);
        chk("rst ready_o", {31'b0, ready_o}, 32'd1);
        @(negedge clk);

        // basic fetch: data_ok at N, valid_o at N+1
        cyc(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h3C080001, 1, 0);
        chk("lit valid", {31'b0, valid_o}, 32'd1);
        chk("lit pc", pc_o, 32'hBFC00000);
        chk("lit inst", inst_o, 32'h3C080001);
        idle(1);

        // cancel while waiting for data
        cyc(1, 32'h80000004, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1); idle(1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0);
        chk("cancel no valid", {31'b0, valid_o}, 32'd0);
        idle(1);
        chk("cancel freed ready", {31'b0, ready_o}, 32'd1);
        chk("cancel freed valid", {31'b0, valid_o}, 32'd0);

        // exception entry needs no bus response
        cyc(1, 32'h80000002, 0, 1, 0, 5'h04, 0, 0, 0, 0);
        chk("exc valid", {31'b0, valid_o}, 32'd1);
        chk("exc exc_o", {31'b0, exc_o}, 32'd1);
        chk("exc code", {27'b0, exccode_o}, 32'h4);
        chk("exc pc", pc_o, 32'h80000002);
        idle(1);
        cyc(1, 32'h80000010, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h11112222, 1, 0);
        chk("post-exc inst", inst_o, 32'h11112222);
        idle(1);

        // decode stall holds outputs
        cyc(1, 32'h80000020, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h24020005, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall inst", inst_o, 32'h24020005);
            chk("stall pc", pc_o, 32'h80000020);
`ifndef IW_DEPTH2_EN
            chk("stall ready_o", {31'b0, ready_o}, 32'd0);
`endif
            idle(0);
        end
        idle(1);
        chk("stall released", {31'b0, valid_o}, 32'd0);

`ifdef IW_DEPTH2_EN
        cyc(1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h80000004, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001, 0, 0);
        chk("d2 first pc", pc_o, 32'h80000000);
        chk("d2 first inst", inst_o, 32'hAAAA0001);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0002, 1, 0);
        chk("d2 second pc", pc_o, 32'h80000004);
        chk("d2 second inst", inst_o, 32'hAAAA0002);
        idle(1);
`endif

        // reset with a pending entry, then a stray response
        cyc(1, 32'h80000040, 0, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h55555555, 1, 0);
        chk("rst stray valid", {31'b0, valid_o}, 32'd0);
        chk("rst stray ready", {31'b0, ready_o}, 32'd1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit v, ex, dok;
            v   = ($urandom_range(0, 1) == 1);
            ex  = ($urandom_range(0, 4) == 0);
            dok = (unfilled() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 700) == 0) do_reset();
            cyc(v, $urandom, ($urandom_range(0, 9) == 0), ex, ex && ($urandom_range(0, 1) == 1),
                ex ? 5'($urandom) : 5'h0, dok, $urandom, ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
